// File: rtl/dmem_responder.sv
// Memory-side end of the CPU data port: word RAM with per-word valid bits,
// a show-ahead write-log FIFO of committed stores, and sticky error status.
module dmem_responder #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          LOG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        overflow,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [15:0] wr_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(LOG_DEPTH);

    logic [31:0]       w_off;
    logic              w_in_range;
    logic              w_aligned;
    logic [ADDR_W-1:0] w_idx;
    logic              w_accept;
    logic              w_reject;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [DEPTH-1:0]  r_valid;
    logic [31:0]       r_fifo_addr [0:LOG_DEPTH-1];
    logic [31:0]       r_fifo_data [0:LOG_DEPTH-1];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [31:0]       r_hold_addr;
    logic [31:0]       r_hold_data;
    logic              r_overflow;
    logic              r_err;
    logic [31:0]       r_err_addr;
    logic [15:0]       r_wr_count;

    assign w_off      = dataaddr - BASE;
    assign w_in_range = (w_off[31:ADDR_W+2] == '0);
    assign w_aligned  = (dataaddr[1:0] == 2'b00);
    assign w_idx      = w_off[ADDR_W+1:2];
    assign w_accept   = memwrite & w_aligned & w_in_range;
    assign w_reject   = memwrite & ~(w_aligned & w_in_range);

    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = log_valid & log_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = w_accept & (~w_full | w_pop);

    // Valid bits clear asynchronously, so reads return zero during reset.
    assign readdata = (w_in_range && r_valid[w_idx]) ? r_mem[w_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_idx] <= writedata;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                end else if (w_accept && (w_idx == ADDR_W'(gi))) begin
                    r_valid[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= dataaddr;
            r_fifo_data[r_wptr] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Shadow of the head so the log outputs keep their last value when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else if (log_valid) begin
            r_hold_addr <= r_fifo_addr[r_rptr];
            r_hold_data <= r_fifo_data[r_rptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_accept) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_accept && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_reject) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= dataaddr;
                end
            end
        end
    end

    assign log_valid = (r_count != '0);
    assign log_addr  = log_valid ? r_fifo_addr[r_rptr] : r_hold_addr;
    assign log_data  = log_valid ? r_fifo_data[r_rptr] : r_hold_data;
    assign overflow  = r_overflow;
    assign err       = r_err;
    assign err_addr  = r_err_addr;
    assign wr_count  = r_wr_count;
endmodule

// File: tb/tb_dmem_responder.sv
// Scenario bench for dmem_responder: a queue holds the expected write-log
// entries, pushed as stores are driven and popped as the log is drained.
module tb_dmem_responder;
    localparam int LD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataaddr = '0;
    logic [31:0] writedata = '0;
    logic        log_ready = 1'b0;
    logic [31:0] readdata;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        overflow;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] wr_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [15:0] exp_wr = '0;
    logic        exp_ovf = 1'b0;

    dmem_responder #(.ADDR_W(6), .BASE(32'h0), .LOG_DEPTH(LD)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata), .readdata(readdata), .log_valid(log_valid),
        .log_ready(log_ready), .log_addr(log_addr), .log_data(log_data),
        .overflow(overflow), .err(err), .err_addr(err_addr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Drives one cycle and updates the model; callers pop exp_q before a
    // cycle with rdy=1 so that a full log is seen as having room.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy);
        memwrite = we; dataaddr = a; writedata = d; log_ready = rdy;
        if (we && a[1:0] == 2'b00 && a < 32'h100) begin
            exp_wr++;
            if (exp_q.size() < LD) exp_q.push_back({a, d});
            else exp_ovf = 1'b1;
        end
        @(posedge clk); #1;
        $display("txn we=%0b addr=%h data=%h rdy=%0b -> wr_count=%0d log_valid=%0b overflow=%0b err=%0b",
                 we, a, d, rdy, wr_count, log_valid, overflow, err);
        memwrite = 1'b0; log_ready = 1'b0;
    endtask

    task automatic apply_reset();
        memwrite = 1'b0; log_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); exp_wr = '0; exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        dataaddr = 32'h00; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd00 got %h want 0", readdata); end
        dataaddr = 32'hFC; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdFC got %h want 0", readdata); end
        n_checks++; if ({log_valid, wr_count, err, overflow} !== 19'h0) begin n_fail++;
            $display("FAIL reset_status got lv=%b wc=%0d err=%b ovf=%b want all 0", log_valid, wr_count, err, overflow); end
        n_checks++; if ({log_addr, log_data, err_addr} !== 96'h0) begin n_fail++;
            $display("FAIL reset_regs got la=%h ld=%h ea=%h want 0", log_addr, log_data, err_addr); end
    endtask

    task automatic test_single_store();
        logic [63:0] exp;
        memwrite = 1'b1; dataaddr = 32'h0C; writedata = 32'd3; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL same_cycle_read got %h want 0", readdata); end
        step(1'b1, 32'h0C, 32'd3, 1'b0);
        dataaddr = 32'h0C; #1;
        n_checks++; if (readdata !== 32'd3) begin n_fail++; $display("FAIL read_0C got %h want 3", readdata); end
        dataaddr = 32'h0E; #1;
        n_checks++; if (readdata !== 32'd3) begin n_fail++; $display("FAIL read_0E_ignore_lsb got %h want 3", readdata); end
        n_checks++; if (wr_count !== exp_wr) begin n_fail++; $display("FAIL wr_count_1 got %0d want %0d", wr_count, exp_wr); end
        n_checks++; if (log_valid !== 1'b1) begin n_fail++; $display("FAIL log_valid_1 got %b want 1", log_valid); end
        exp = exp_q.pop_front();
        n_checks++; if ({log_addr, log_data} !== exp) begin n_fail++;
            $display("FAIL log_head got %h/%h want %h/%h", log_addr, log_data, exp[63:32], exp[31:0]); end
        step(1'b0, 32'h0C, 32'h0, 1'b1);
        n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty got %b want 0", log_valid); end
        n_checks++; if ({log_addr, log_data} !== {32'h0C, 32'd3}) begin n_fail++;
            $display("FAIL log_hold got %h/%h want 0000000c/00000003", log_addr, log_data); end
    endtask

    task automatic test_errors();
        step(1'b1, 32'h03, 32'hDEAD, 1'b0);
        step(1'b1, 32'h100, 32'hBEEF, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
        n_checks++; if (err_addr !== 32'h03) begin n_fail++; $display("FAIL err_addr got %h want 00000003", err_addr); end
        n_checks++; if (wr_count !== exp_wr) begin n_fail++; $display("FAIL err_wr_count got %0d want %0d", wr_count, exp_wr); end
        n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL err_fifo got %b want 0", log_valid); end
        dataaddr = 32'h00; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL err_read00 got %h want 0", readdata); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp;
        int n;
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
        n_checks++; if (overflow !== exp_ovf || overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %b want 1", overflow); end
        n_checks++; if (wr_count !== exp_wr) begin n_fail++; $display("FAIL ovf_wr_count got %0d want %0d", wr_count, exp_wr); end
        dataaddr = 32'h10; #1;
        n_checks++; if (readdata !== 32'd5) begin n_fail++; $display("FAIL ovf_read10 got %h want 5", readdata); end
        n = 0;
        while (log_valid && n < 8) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            n_checks++; if ({log_addr, log_data} !== exp || log_data !== 32'(n + 1)) begin n_fail++;
                $display("FAIL ovf_drain%0d got %h/%h want %h/%h", n, log_addr, log_data, exp[63:32], exp[31:0]); end
            step(1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 4", n); end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp;
        logic [63:0] last;
        int n;
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'(11 + i), 1'b0);
        exp = exp_q.pop_front();
        n_checks++; if ({log_addr, log_data} !== exp) begin n_fail++;
            $display("FAIL full_head got %h/%h want %h/%h", log_addr, log_data, exp[63:32], exp[31:0]); end
        step(1'b1, 32'h20, 32'd9, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf got %b want 0", overflow); end
        n = 0; last = '0;
        while (log_valid && n < 8) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            n_checks++; if ({log_addr, log_data} !== exp) begin n_fail++;
                $display("FAIL full_drain%0d got %h/%h want %h/%h", n, log_addr, log_data, exp[63:32], exp[31:0]); end
            last = {log_addr, log_data};
            step(1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL full_occupancy got %0d want 4", n); end
        n_checks++; if (last !== {32'h20, 32'd9}) begin n_fail++;
            $display("FAIL full_last got %h want 00000020/00000009", last); end
    endtask

    task automatic test_reset_mid_burst();
        step(1'b1, 32'h30, 32'hA, 1'b0);
        step(1'b1, 32'h101, 32'hB, 1'b0);
        step(1'b1, 32'h34, 32'hC, 1'b0);
        memwrite = 1'b1; dataaddr = 32'h30; writedata = 32'h7; #1;
        n_checks++; if (readdata !== 32'hA) begin n_fail++; $display("FAIL pre_reset_read got %h want a", readdata); end
        reset = 1'b1; #1;
        n_checks++; if ({readdata, log_valid, wr_count, err, overflow} !== 51'h0) begin n_fail++;
            $display("FAIL async_reset got rd=%h lv=%b wc=%0d err=%b ovf=%b want 0", readdata, log_valid, wr_count, err, overflow); end
        n_checks++; if ({log_addr, log_data, err_addr} !== 96'h0) begin n_fail++;
            $display("FAIL async_reset_regs got la=%h ld=%h ea=%h want 0", log_addr, log_data, err_addr); end
        #4;
        memwrite = 1'b0; reset = 1'b0;
        exp_q.delete(); exp_wr = '0; exp_ovf = 1'b0;
        @(posedge clk); #1;
        dataaddr = 32'h34; #1;
        n_checks++; if (readdata !== 32'h0 || wr_count !== 16'd0) begin n_fail++;
            $display("FAIL post_reset got rd=%h wc=%0d want 0/0", readdata, wr_count); end
        step(1'b1, 32'h30, 32'h55, 1'b0);
        dataaddr = 32'h30; #1;
        n_checks++; if (readdata !== 32'h55 || wr_count !== exp_wr) begin n_fail++;
            $display("FAIL post_reset_store got rd=%h wc=%0d want 55/%0d", readdata, wr_count, exp_wr); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_errors();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
